// File: rtl/apb_timer.sv
// APB3/APB4 zero-wait-state timer: 32-bit down-counter behind a 16-bit prescaler,
// periodic or one-shot, with a sticky W1C expiry flag and a level interrupt.
module apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    IRQ
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_LOAD     = 3'd2;
    localparam logic [2:0] A_VALUE    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    logic        en_r, oneshot_r, irq_en_r, exp_r;
    logic [15:0] prescale_r, pcnt_r;
    logic [31:0] load_r, value_r;

    logic        access_s, err_s, tick_s, expire_s;
    logic        wr_ctrl_s, wr_prescale_s, wr_load_s, wr_status_s;
    logic [2:0]  addr_s;
    logic [31:0] rdata_s, load_merged_s, prescale_merged_s;
    logic        unused_s;

    assign unused_s = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
    assign PREADY   = 1'b1;
    assign IRQ      = exp_r & irq_en_r;

    // Bus decode, read mux, error response and tick/expiry qualification
    always_comb begin
        access_s          = PSEL & PENABLE;
        addr_s            = PADDR[4:2];
        load_merged_s     = merge_bytes(load_r, PWDATA, PSTRB);
        prescale_merged_s = merge_bytes({16'h0000, prescale_r}, PWDATA, PSTRB);
        wr_ctrl_s         = access_s & PWRITE & (addr_s == A_CTRL);
        wr_prescale_s     = access_s & PWRITE & (addr_s == A_PRESCALE);
        wr_load_s         = access_s & PWRITE & (addr_s == A_LOAD);
        wr_status_s       = access_s & PWRITE & (addr_s == A_STATUS);
        case (addr_s)
            A_CTRL: begin
                err_s   = 1'b0;
                rdata_s = {29'h0, irq_en_r, oneshot_r, en_r};
            end
            A_PRESCALE: begin
                err_s   = 1'b0;
                rdata_s = {16'h0000, prescale_r};
            end
            A_LOAD: begin
                err_s   = 1'b0;
                rdata_s = load_r;
            end
            A_VALUE: begin
                err_s   = PWRITE;
                rdata_s = value_r;
            end
            A_STATUS: begin
                err_s   = 1'b0;
                rdata_s = {31'h0, exp_r};
            end
            default: begin
                err_s   = 1'b1;
                rdata_s = 32'h0000_0000;
            end
        endcase
        PSLVERR = access_s & err_s;
        if (access_s && !PWRITE && !err_s) begin
            PRDATA = rdata_s;
        end else begin
            PRDATA = 32'h0000_0000;
        end
        // A LOAD write in the same cycle discards the tick entirely
        tick_s   = en_r & (pcnt_r == prescale_r) & ~wr_load_s;
        expire_s = tick_s & (value_r == 32'h0000_0000);
    end

    // Software-visible configuration registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_r       <= 1'b0;
            oneshot_r  <= 1'b0;
            irq_en_r   <= 1'b0;
            prescale_r <= 16'h0000;
            load_r     <= 32'h0000_0000;
        end else begin
            if (wr_ctrl_s && PSTRB[0]) begin
                en_r      <= PWDATA[0];
                oneshot_r <= PWDATA[1];
                irq_en_r  <= PWDATA[2];
            end else if (expire_s && oneshot_r) begin
                en_r <= 1'b0;
            end
            if (wr_prescale_s) begin
                prescale_r <= prescale_merged_s[15:0];
            end
            if (wr_load_s) begin
                load_r <= load_merged_s;
            end
        end
    end

    // Prescale counter, down-counter and sticky expiry flag
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pcnt_r  <= 16'h0000;
            value_r <= 32'h0000_0000;
            exp_r   <= 1'b0;
        end else begin
            if (!en_r || wr_load_s || tick_s) begin
                pcnt_r <= 16'h0000;
            end else begin
                pcnt_r <= pcnt_r + 16'h0001;
            end
            if (wr_load_s) begin
                value_r <= load_merged_s;
            end else if (tick_s) begin
                if (value_r != 32'h0000_0000) begin
                    value_r <= value_r - 32'h0000_0001;
                end else if (!oneshot_r) begin
                    value_r <= load_r;
                end
            end
            if (expire_s) begin
                exp_r <= 1'b1;
            end else if (wr_status_s && PSTRB[0] && PWDATA[0]) begin
                exp_r <= 1'b0;
            end
        end
    end

endmodule
